// File: rtl/pipelined_multiplier.sv
// Fully pipelined unsigned multiplier returning the low DATA_LEN bits of a*b.
// Partial products over slices of b accumulate across PIPELINE_STAGE-1 register stages.
module pipelined_multiplier #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic [DATA_LEN-1:0] result
);

    localparam int NSTG    = PIPELINE_STAGE - 1;
    localparam int SLICE_W = (NSTG > 0) ? DATA_LEN / NSTG : DATA_LEN;

    // Bits of b handled by stage idx; the last stage absorbs any remainder.
    function automatic logic [DATA_LEN-1:0] slice_mask(input int idx);
        logic [DATA_LEN-1:0] m;
        m = '0;
        for (int k = 0; k < DATA_LEN; k++) begin
            if (k >= idx * SLICE_W && (idx == NSTG - 1 || k < (idx + 1) * SLICE_W)) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

    if (PIPELINE_STAGE < 1 || PIPELINE_STAGE > 8) begin : g_bad_param
        $error("PIPELINE_STAGE must be in 1..8");
    end

    if (NSTG == 0) begin : g_comb
        assign result = a * b;
    end else begin : g_pipe
        for (genvar i = 0; i < NSTG; i++) begin : g_stage
            localparam logic [DATA_LEN-1:0] MASK = slice_mask(i);

            logic [DATA_LEN-1:0] a_in;
            logic [DATA_LEN-1:0] b_in;
            logic [DATA_LEN-1:0] sum_in;
            logic [DATA_LEN-1:0] sum_out;

            if (i == 0) begin : g_first
                assign a_in   = a;
                assign b_in   = b;
                assign sum_in = '0;
            end else begin : g_reg
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        a_in   <= '0;
                        b_in   <= '0;
                        sum_in <= '0;
                    end else begin
                        a_in   <= g_stage[i-1].a_in;
                        b_in   <= g_stage[i-1].b_in;
                        sum_in <= g_stage[i-1].sum_out;
                    end
                end
            end

            // Masking b in place equals a*slice shifted by the slice offset.
            assign sum_out = sum_in + a_in * (b_in & MASK);
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                result <= '0;
            end else begin
                result <= g_stage[NSTG-1].sum_out;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Scoreboard bench for pipelined_multiplier at PIPELINE_STAGE = 2, 4 and 1 side by side.
module tb_pipelined_multiplier;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r2;
    logic [31:0] r4;
    logic [31:0] r1;

    typedef struct {
        logic [31:0] exp;
        int          due;
    } exp_t;

    exp_t q2[$];
    exp_t q4[$];
    exp_t q1[$];

    int cycle;
    int compared;
    int mismatched;

    pipelined_multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(2)) u_dut2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(r2)
    );
    pipelined_multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(4)) u_dut4 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(r4)
    );
    pipelined_multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(1)) u_dut1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(r1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    // One vector per cycle, driven just after the edge; expected values are hand-computed.
    task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        a = va;
        b = vb;
        e.exp = exp;
        e.due = cycle + 1;
        q2.push_back(e);
        e.due = cycle + 3;
        q4.push_back(e);
        e.due = cycle;
        q1.push_back(e);
    endtask

    // Monitor: pops each queue when its entry falls due.
    always @(negedge clk) begin
        exp_t e;
        if (q2.size() > 0 && q2[0].due <= cycle) begin
            e = q2.pop_front();
            checkOutput((e.due == cycle) ? "ps2" : "ps2_late", r2, e.exp);
        end
        if (q4.size() > 0 && q4[0].due <= cycle) begin
            e = q4.pop_front();
            checkOutput((e.due == cycle) ? "ps4" : "ps4_late", r4, e.exp);
        end
        if (q1.size() > 0 && q1[0].due <= cycle) begin
            e = q1.pop_front();
            checkOutput((e.due == cycle) ? "ps1" : "ps1_late", r1, e.exp);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        a          = '0;
        b          = '0;

        #1;
        checkOutput("reset_ps2", r2, 32'd0);
        checkOutput("reset_ps4", r4, 32'd0);

        a = 32'd5;
        b = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold_ps2", r2, 32'd0);
        checkOutput("reset_hold_ps4", r4, 32'd0);
        checkOutput("reset_comb_ps1", r1, 32'd35);

        a = '0;
        b = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        applyStimulus(32'd0, 32'd0, 32'd0);
        applyStimulus(32'd3, 32'd5, 32'd15);
        applyStimulus(32'd0, 32'd0, 32'd0);
        applyStimulus(32'd0, 32'd0, 32'd0);

        applyStimulus(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        applyStimulus(32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        applyStimulus(32'd65535, 32'd65537, 32'hFFFF_FFFF);
        applyStimulus(32'd0, 32'd0, 32'd0);

        applyStimulus(32'd7, 32'd6, 32'd42);
        applyStimulus(32'd100, 32'd100, 32'd10000);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        applyStimulus(32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
        applyStimulus(32'd0, 32'd0, 32'd0);
        repeat (4) applyStimulus(32'd0, 32'd0, 32'd0);

        // In-flight product is discarded by an asynchronous reset mid-cycle.
        applyStimulus(32'd1234, 32'd1000, 32'd1234000);
        #2;
        reset = 1'b0;
        q2.delete();
        q4.delete();
        q1.delete();
        #1;
        checkOutput("async_reset_ps2", r2, 32'd0);
        checkOutput("async_reset_ps4", r4, 32'd0);
        checkOutput("async_reset_ps1", r1, 32'd1234000);
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("post_reset_ps2", r2, 32'd0);
            checkOutput("post_reset_ps4", r4, 32'd0);
            checkOutput("post_reset_ps1", r1, 32'd0);
        end

        applyStimulus(32'd7, 32'd6, 32'd42);
        applyStimulus(32'd100, 32'd100, 32'd10000);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        applyStimulus(32'd0, 32'd0, 32'd0);

        repeat (6) @(posedge clk);
        #1;
        checkOutput("drain_ps2", 32'(q2.size()), 32'd0);
        checkOutput("drain_ps4", 32'(q4.size()), 32'd0);
        checkOutput("drain_ps1", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
